icache_fetch: RTL and testbench

Direct-mapped, read-only instruction cache between the single-cycle datapath's `pc`/`instr` port and a slower instruction memory with a req/ack handshake. Hits return the instruction combinationally in the same cycle. Misses stall the core via `instr_valid` = 0 while a full line is refilled word by word. A flush input invalidates the whole cache for self-modifying or reloaded code.

---
 rtl/icache_pkg.sv | 22 ++
 rtl/icache_line_store.sv | 57 +++++
 rtl/icache_fetch.sv | 140 ++++++++++++++
 tb/tb_icache_fetch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared FSM state type and address-split width helpers for icache_fetch
package icache_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_REFILL = 1'b1
  } fetch_state_t;

  function automatic int offset_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag covers the word address (30 bits) minus offset and index fields.
  function automatic int tag_w(input int lines, input int words_per_line);
    return 30 - $clog2(lines) - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// rtl/icache_line_store.sv - valid/tag/data arrays with combinational read, word write, install and invalidate
module icache_line_store
  import icache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  localparam int OW = offset_w(WORDS_PER_LINE),
  localparam int IW = index_w(LINES),
  localparam int TW = tag_w(LINES, WORDS_PER_LINE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_index,
  input  logic [OW-1:0] rd_offset,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_index,
  input  logic [OW-1:0] wr_offset,
  input  logic [31:0]   wr_data,
  input  logic          inst_en,
  input  logic [IW-1:0] inst_index,
  input  logic [TW-1:0] inst_tag,
  input  logic          inst_valid,
  input  logic          invalidate
);

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      data_q [LINES*WORDS_PER_LINE];

  // Invalidate wins over a same-cycle install so a flush can never be undone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (invalidate) begin
      valid_q <= '0;
    end else if (inst_en) begin
      valid_q[inst_index] <= inst_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[{wr_index, wr_offset}] <= wr_data;
    end
    if (inst_en) begin
      tag_q[inst_index] <= inst_tag;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[{rd_index, rd_offset}];

endmodule

// File: rtl/icache_fetch.sv
// rtl/icache_fetch.sv - direct-mapped read-only instruction cache with word-by-word line refill
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_fetch
  import icache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OW = offset_w(WORDS_PER_LINE);
  localparam int IW = index_w(LINES);
  localparam int TW = tag_w(LINES, WORDS_PER_LINE);
  localparam int LW = 30 - OW;

  fetch_state_t  state_q, state_d;
  logic [LW-1:0] line_q;
  logic [OW-1:0] cnt_q;
  logic          drop_q;

  logic          rd_valid;
  logic [TW-1:0] rd_tag;
  logic [31:0]   rd_data;
  logic          hit;
  logic          miss_start;
  logic          ack_word;
  logic          last_word;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^pc[1:0];

  icache_line_store #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (pc[OW+2 +: IW]),
    .rd_offset  (pc[2 +: OW]),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .wr_en      (ack_word),
    .wr_index   (line_q[IW-1:0]),
    .wr_offset  (cnt_q),
    .wr_data    (mem_rdata),
    .inst_en    (ack_word && last_word),
    .inst_index (line_q[IW-1:0]),
    .inst_tag   (line_q[LW-1:IW]),
    .inst_valid (!(drop_q || flush)),
    .invalidate (flush)
  );

  assign last_word = (cnt_q == {OW{1'b1}});
  assign ack_word  = mem_req && mem_ack;
  assign mem_addr  = {line_q, cnt_q, 2'b00};

  always_comb begin
    state_d     = state_q;
    hit         = 1'b0;
    miss_start  = 1'b0;
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'h0;
    case (state_q)
      S_IDLE: begin
        hit = rd_valid && (rd_tag == pc[31 -: TW]) && !flush;
        if (hit) begin
          instr_valid = 1'b1;
          instr       = rd_data;
        end else if (!flush) begin
          miss_start = 1'b1;
          state_d    = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_req = 1'b1;
        if (mem_ack && last_word) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        line_q <= pc[31:OW+2];
        cnt_q  <= '0;
      end else if (ack_word) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // A flush seen during a burst keeps the refilled line from being marked valid.
      if (ack_word && last_word) begin
        drop_q <= 1'b0;
      end else if (mem_req && flush) begin
        drop_q <= 1'b1;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (instr_valid) begin
        hit_count <= hit_count + 32'h1;
      end
      if (miss_start) begin
        miss_count <= miss_count + 32'h1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// tb/tb_icache_fetch.sv - self-checking bench for icache_fetch against a behavioural cache/memory model
module tb_icache_fetch;

  localparam int LINES = 16;
  localparam int WPL   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_fetch #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // behavioural model: which memory line each cache slot holds
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];

  // memory responder configuration and observations
  int          max_wait   = 0;
  bit          fixed_wait = 1'b1;
  int          waits_total;
  bit          in_word;
  int          wait_left;
  logic [31:0] held_addr;
  logic [31:0] req_log [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a & 32'hFFFF_FFFC) * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    in_word   = 1'b0;
    wait_left = 0;
    held_addr = 32'h0;
    waits_total = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req !== 1'b1) begin
        in_word = 1'b0;
      end else begin
        if (!in_word) begin
          in_word   = 1'b1;
          wait_left = fixed_wait ? max_wait : int'($urandom_range(max_wait, 0));
          waits_total += wait_left;
          held_addr = mem_addr;
        end else begin
          check32("addr_stable", mem_addr, held_addr);
        end
        if (wait_left == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          req_log.push_back(mem_addr);
          in_word   = 1'b0;
        end else begin
          wait_left--;
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a);
    int unsigned word, idx, tg;
    int stall;
    logic [31:0] base;
    bit exp_hit;
    @(posedge clk); #1;
    pc    = a;
    flush = 1'b0;
    word  = a >> 2;
    idx   = (word / WPL) % LINES;
    tg    = word / (WPL * LINES);
    base  = a & ~(32'(WPL * 4) - 32'h1);
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    req_log.delete();
    waits_total = 0;
    @(negedge clk);
    if (exp_hit) begin
      check32("hit_valid", 32'(instr_valid), 32'h1);
      check32("hit_instr", instr, mem_word(a));
      check32("hit_no_req", 32'(mem_req), 32'h0);
    end else begin
      check32("miss_valid", 32'(instr_valid), 32'h0);
      check32("miss_instr", instr, 32'h0);
      stall = 0;
      while (instr_valid !== 1'b1 && stall < 300) begin
        stall++;
        @(negedge clk);
      end
      check32("miss_stall", 32'(stall), 32'(1 + WPL + waits_total));
      check32("refill_instr", instr, mem_word(a));
      check32("burst_len", 32'(req_log.size()), 32'(WPL));
      for (int i = 0; i < WPL; i++) begin
        check32("burst_addr", (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF, base + 32'(4 * i));
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    pc    = 32'h0;
    flush = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_valid", 32'(instr_valid), 32'h0);
    check32("rst_instr", instr, 32'h0);
    check32("rst_req", 32'(mem_req), 32'h0);
    check32("rst_addr", mem_addr, 32'h0);
    flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // first fill from zero-wait memory, then sequential hits
    fetch(32'h0000_0000);
    for (int i = 0; i < WPL; i++) fetch(32'(4 * i));

    // conflicting tag on index 0 evicts the line
    fetch(32'h0000_0100);
    fetch(32'h0000_0000);

    // three wait cycles per word
    max_wait = 3;
    fetch(32'h0000_0200);
    fetch(32'h0000_0208);

    // random traffic with random wait states
    fixed_wait = 1'b0;
    max_wait   = 2;
    for (int i = 0; i < 80; i++) fetch($urandom_range(32'h0000_0FFF, 0));
    fixed_wait = 1'b1;
    max_wait   = 0;

    // flush during a refill: burst completes, line not installed, refilled again
    @(posedge clk); #1;
    pc = 32'h0000_2400;
    @(negedge clk);
    check32("fl_miss", 32'(instr_valid), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check32("fl_in_burst", 32'(mem_req), 32'h1);
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mem_req === 1'b1 && n < 50);
    check32("fl_burst_done", 32'(mem_req), 32'h0);
    check32("fl_not_installed", 32'(instr_valid), 32'h0);
    @(negedge clk);
    check32("fl_rerequest", 32'(mem_req), 32'h1);
    check32("fl_rerequest_addr", mem_addr, 32'h0000_2400);
    n = 0;
    while (instr_valid !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check32("fl_refill_instr", instr, mem_word(32'h0000_2400));
    m_valid[0] = 1'b1;
    m_tag[0]   = 32'h0000_2400 >> 8;

    // flush while hitting: same cycle and next cycle both stall
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check32("flh_same_cycle", 32'(instr_valid), 32'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
    @(negedge clk);
    check32("flh_next_cycle", 32'(instr_valid), 32'h0);
    n = 0;
    while (instr_valid !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check32("flh_refill_instr", instr, mem_word(32'h0000_2400));
    m_valid[0] = 1'b1;
    m_tag[0]   = 32'h0000_2400 >> 8;
    fetch(32'h0000_2404);

    // asynchronous reset in the middle of a refill
    max_wait = 2;
    @(posedge clk); #1;
    pc = 32'h0000_3000;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check32("arst_req", 32'(mem_req), 32'h0);
    check32("arst_valid", 32'(instr_valid), 32'h0);
    check32("arst_addr", mem_addr, 32'h0);
    model_clear();
    max_wait = 0;
    flush = 1'b1;
    pc = 32'h0001_0000;
    @(posedge clk); #1;
`ifdef ICACHE_STATS_EN
    check32("stat_rst_hits", hit_count, 32'h0);
    check32("stat_rst_miss", miss_count, 32'h0);
`endif
    rst = 1'b0;
    fetch(32'h0001_0000);
    fetch(32'h0001_0004);
    fetch(32'h0001_0008);
    fetch(32'h0001_000C);
`ifdef ICACHE_STATS_EN
    @(posedge clk); #1;
    check32("stat_hits", hit_count, 32'd4);
    check32("stat_miss", miss_count, 32'd1);
`endif
    fetch(32'h0000_2400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
